wb_cmd_master: RTL and testbench
================================

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max cycles CYC/STB is held waiting for WBs_ACK; legal range 1..65535.
REQ-002 WB_CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 WB_RST  input  1  reset; synchronous, active-high.
REQ-004 cmd_valid_i  input  1  command request.
REQ-005 cmd_ready_o  output  1  command accept; transfer when cmd_valid_i & cmd_ready_o at a rising edge.
REQ-006 cmd_we_i  input  1  1=write, 0=read.
REQ-007 cmd_adr_i  input  17  byte address.
REQ-008 cmd_sel_i  input  4  write byte enables.
REQ-009 cmd_dat_i  input  32  write data.
REQ-010 rsp_valid_o  output  1  response available.
REQ-011 rsp_ready_i  input  1  response consumed; transfer when rsp_valid_o & rsp_ready_i at a rising edge.
REQ-012 rsp_dat_o  output  32  read data; 0 for writes and timeouts.
REQ-013 rsp_err_o  output  1  1=transaction timed out.
REQ-014 WBs_ADR  output  17  Wishbone address.
REQ-015 WBs_CYC  output  1  cycle strobe.
REQ-016 WBs_STB  output  1  transfer strobe.
REQ-017 WBs_WE  output  1  write enable.
REQ-018 WBs_RD  output  1  read enable.
REQ-019 WBs_BYTE_STB  output  4  byte enables.
REQ-020 WBs_WR_DAT  output  32  write data.
REQ-021 WBs_RD_DAT  input  32  read data from slave.
REQ-022 WBs_ACK  input  1  slave acknowledge.
REQ-023 busy_o  output  1  high in any state other than IDLE.

Function
REQ-024 The FSM SHALL have states IDLE, BUS, RESP; cmd_ready_o = 1 only in IDLE.
REQ-025 On command transfer the block SHALL register adr/we/sel/dat and enter BUS; WBs_CYC=WBs_STB=1 from the next cycle (1-cycle latency).
REQ-026 In BUS: WBs_WE=cmd_we, WBs_RD=~cmd_we, WBs_ADR/WBs_WR_DAT held from registered command, all stable until exit.
REQ-027 WBs_BYTE_STB SHALL equal registered cmd_sel_i for writes and 4'hF for reads.
REQ-028 Outside BUS, WBs_CYC, WBs_STB, WBs_WE, WBs_RD SHALL be 0; WBs_ADR, WBs_BYTE_STB, WBs_WR_DAT SHALL be 0.
REQ-029 A 16-bit wait counter SHALL clear on entering BUS and increment each BUS cycle without WBs_ACK.
REQ-030 WBs_ACK sampled high in BUS SHALL: capture WBs_RD_DAT (reads) or 0 (writes) into rsp_dat_o, rsp_err_o=0, go to RESP; CYC/STB low on the following cycle.
REQ-031 If counter reaches TIMEOUT_CYCLES with WBs_ACK low, the block SHALL go to RESP with rsp_err_o=1, rsp_dat_o=0, dropping CYC/STB the following cycle.
REQ-032 WBs_ACK and timeout on the same edge: ACK SHALL win (normal completion).
REQ-033 In RESP rsp_valid_o=1 with rsp_dat_o/rsp_err_o stable until response transfer, then IDLE; rsp_valid_o=0 in all other states.
REQ-034 WBs_ACK in IDLE or RESP SHALL be ignored (no state/data change).
REQ-035 Changes to cmd_* inputs after transfer SHALL not affect the bus cycle in progress.
REQ-036 Minimum issue interval SHALL be 3 cycles per transaction (IDLE, BUS, RESP with zero-wait ACK and rsp_ready_i high).

Reset
REQ-037 WB_RST high at a rising edge SHALL force IDLE, clear counter and all registers; outputs: cmd_ready_o=1, rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=0, busy_o=0, all WBs_* outputs 0.
REQ-038 Reset mid-BUS SHALL drop WBs_CYC/WBs_STB on the next cycle and discard the transaction with no response generated.

Verification
REQ-039 Write adr=17'h01000, sel=4'h3, dat=32'hA5A5_1234, slave ACK after 2 waits -> CYC/STB high 3 cycles, WE=1, BYTE_STB=4'h3, rsp_valid with dat=0, err=0.
REQ-040 Read adr=17'h01004, zero-wait ACK, WBs_RD_DAT=32'hCAFE_0001 -> RD=1, BYTE_STB=4'hF, rsp_dat_o=32'hCAFE_0001, err=0.
REQ-041 TIMEOUT_CYCLES=4, slave never ACKs -> CYC drops after timeout, rsp_err_o=1, rsp_dat_o=0; later stray ACK ignored.
REQ-042 ACK asserted exactly on timeout edge -> normal completion, err=0, data captured.
REQ-043 rsp_ready_i held low 10 cycles -> rsp_valid_o and data stable, cmd_ready_o=0 throughout; next command accepted only after response transfer.
REQ-044 WB_RST pulsed during BUS with ACK pending -> all outputs at reset values next cycle, no rsp_valid_o, subsequent read completes normally.

Source files
------------

// File: rtl/wb_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : wb_cmd_master
//  Description : Single-outstanding command-to-Wishbone master. Accepts a
//                read/write command on a valid/ready port, runs one Wishbone
//                classic cycle with a bounded wait for ACK, and returns the
//                read data (or a timeout error) on a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_cmd_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        WB_CLK,
    input  logic        WB_RST,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [16:0] cmd_adr_i,
    input  logic [3:0]  cmd_sel_i,
    input  logic [31:0] cmd_dat_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,

    output logic [16:0] WBs_ADR,
    output logic        WBs_CYC,
    output logic        WBs_STB,
    output logic        WBs_WE,
    output logic        WBs_RD,
    output logic [3:0]  WBs_BYTE_STB,
    output logic [31:0] WBs_WR_DAT,
    input  logic [31:0] WBs_RD_DAT,
    input  logic        WBs_ACK,

    output logic        busy_o
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_bus  = 2'd1;
    localparam logic [1:0] c_resp = 2'd2;

    // Timeout fires on the last permitted BUS cycle, so CYC/STB is held for
    // at most TIMEOUT_CYCLES cycles.
    localparam logic [15:0] c_wait_last = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_next;

    logic        r_we;
    logic [16:0] r_adr;
    logic [3:0]  r_sel;
    logic [31:0] r_wdat;
    logic [15:0] r_wait;
    logic [31:0] r_rsp_dat;
    logic        r_rsp_err;

    logic        w_timeout;

    assign w_timeout = (r_wait == c_wait_last);

    // State register
    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; ACK takes priority over timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle: if (cmd_valid_i)             w_next = c_bus;
            c_bus:  if (WBs_ACK || w_timeout)    w_next = c_resp;
            c_resp: if (rsp_ready_i)             w_next = c_idle;
            default:                             w_next = c_idle;
        endcase
    end

    // Command capture, wait counter and response capture
    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_sel     <= '0;
            r_wdat    <= '0;
            r_wait    <= '0;
            r_rsp_dat <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (r_state == c_idle && cmd_valid_i) begin
                r_we   <= cmd_we_i;
                r_adr  <= cmd_adr_i;
                r_sel  <= cmd_sel_i;
                r_wdat <= cmd_dat_i;
                r_wait <= '0;
            end
            if (r_state == c_bus) begin
                if (WBs_ACK) begin
                    r_rsp_dat <= r_we ? 32'h0 : WBs_RD_DAT;
                    r_rsp_err <= 1'b0;
                end else if (w_timeout) begin
                    r_rsp_dat <= 32'h0;
                    r_rsp_err <= 1'b1;
                end else begin
                    r_wait <= r_wait + 16'd1;
                end
            end
        end
    end

    // Outputs decoded from state; bus fields forced to zero outside BUS
    always_comb begin
        cmd_ready_o  = (r_state == c_idle);
        rsp_valid_o  = (r_state == c_resp);
        busy_o       = (r_state != c_idle);
        WBs_CYC      = 1'b0;
        WBs_STB      = 1'b0;
        WBs_WE       = 1'b0;
        WBs_RD       = 1'b0;
        WBs_ADR      = '0;
        WBs_BYTE_STB = '0;
        WBs_WR_DAT   = '0;
        if (r_state == c_bus) begin
            WBs_CYC      = 1'b1;
            WBs_STB      = 1'b1;
            WBs_WE       = r_we;
            WBs_RD       = ~r_we;
            WBs_ADR      = r_adr;
            WBs_BYTE_STB = r_we ? r_sel : 4'hF;
            WBs_WR_DAT   = r_wdat;
        end
    end

    assign rsp_dat_o = r_rsp_dat;
    assign rsp_err_o = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_cmd_master
//  Description : Self-checking bench for wb_cmd_master (TIMEOUT_CYCLES=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_cmd_master;

    localparam int TO = 4;

    logic        WB_CLK = 1'b0;
    logic        WB_RST = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [16:0] cmd_adr_i = '0;
    logic [3:0]  cmd_sel_i = '0;
    logic [31:0] cmd_dat_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic [16:0] WBs_ADR;
    logic        WBs_CYC;
    logic        WBs_STB;
    logic        WBs_WE;
    logic        WBs_RD;
    logic [3:0]  WBs_BYTE_STB;
    logic [31:0] WBs_WR_DAT;
    logic [31:0] WBs_RD_DAT = '0;
    logic        WBs_ACK = 1'b0;
    logic        busy_o;

    wb_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
        .WB_CLK(WB_CLK), .WB_RST(WB_RST),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_we_i(cmd_we_i), .cmd_adr_i(cmd_adr_i),
        .cmd_sel_i(cmd_sel_i), .cmd_dat_i(cmd_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
        .WBs_ADR(WBs_ADR), .WBs_CYC(WBs_CYC), .WBs_STB(WBs_STB),
        .WBs_WE(WBs_WE), .WBs_RD(WBs_RD), .WBs_BYTE_STB(WBs_BYTE_STB),
        .WBs_WR_DAT(WBs_WR_DAT), .WBs_RD_DAT(WBs_RD_DAT), .WBs_ACK(WBs_ACK),
        .busy_o(busy_o)
    );

    always #5 WB_CLK = ~WB_CLK;

    typedef struct {
        logic        we;
        logic [16:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          waits;     // BUS cycles before ACK; >= TO means never
        logic [31:0] rd_dat;
        int          hold;      // cycles rsp_ready_i is held low
        logic        exp_err;
        logic [31:0] exp_dat;
        int          exp_cyc;   // expected number of cycles CYC is high
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] dat;
    } rsp_t;

    rsp_t sb[$];
    vec_t vecs[7];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string n);
        chk({n, "_ctl"},
            64'({cmd_ready_o, rsp_valid_o, busy_o, WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_BYTE_STB}),
            64'(11'b100_0000_0000));
        chk({n, "_bus"}, 64'({WBs_ADR, WBs_WR_DAT}), 64'd0);
    endtask

    function automatic vec_t mk(input logic we, input logic [16:0] adr, input logic [3:0] sel,
                                input logic [31:0] dat, input int waits, input logic [31:0] rd,
                                input int hold, input logic eerr, input logic [31:0] edat,
                                input int ecyc);
        vec_t v;
        v.we = we; v.adr = adr; v.sel = sel; v.dat = dat; v.waits = waits;
        v.rd_dat = rd; v.hold = hold; v.exp_err = eerr; v.exp_dat = edat; v.exp_cyc = ecyc;
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        int   g;
        int   cyc_n;
        rsp_t e;
        rsp_t got;
        cmd_valid_i = 1'b1;
        cmd_we_i    = v.we;
        cmd_adr_i   = v.adr;
        cmd_sel_i   = v.sel;
        cmd_dat_i   = v.dat;
        g = 0;
        while (!cmd_ready_o && g < 20) begin
            @(negedge WB_CLK);
            g++;
        end
        chk("cmd_ready", 64'(cmd_ready_o), 64'd1);
        e.err = v.exp_err;
        e.dat = v.exp_dat;
        sb.push_back(e);
        @(negedge WB_CLK);
        // scramble the command port; the bus cycle must not follow it
        cmd_valid_i = 1'b0;
        cmd_we_i    = ~v.we;
        cmd_adr_i   = ~v.adr;
        cmd_sel_i   = ~v.sel;
        cmd_dat_i   = ~v.dat;
        chk("cyc_latency", 64'(WBs_CYC), 64'd1);
        cyc_n = 0;
        while (WBs_CYC && cyc_n < 100) begin
            chk("bus_ctl", 64'({WBs_STB, WBs_WE, WBs_RD, WBs_BYTE_STB, busy_o, cmd_ready_o}),
                64'({1'b1, v.we, ~v.we, (v.we ? v.sel : 4'hF), 1'b1, 1'b0}));
            chk("bus_adr", 64'(WBs_ADR), 64'(v.adr));
            chk("bus_wdat", 64'(WBs_WR_DAT), 64'(v.dat));
            WBs_ACK    = (cyc_n == v.waits);
            WBs_RD_DAT = WBs_ACK ? v.rd_dat : $urandom;
            @(negedge WB_CLK);
            cyc_n++;
        end
        WBs_ACK = 1'b0;
        chk("cyc_len", 64'(cyc_n), 64'(v.exp_cyc));
        chk("resp_valid", 64'({rsp_valid_o, busy_o, cmd_ready_o}), 64'(3'b110));
        chk("resp_bus", 64'({WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_BYTE_STB, WBs_ADR, WBs_WR_DAT}), 64'd0);
        for (int i = 0; i < v.hold; i++) begin
            // stray ACKs and a waiting command must not disturb RESP
            cmd_valid_i = 1'b1;
            WBs_ACK     = i[0];
            WBs_RD_DAT  = $urandom;
            @(negedge WB_CLK);
            chk("hold_ctl", 64'({rsp_valid_o, cmd_ready_o, WBs_CYC}), 64'(3'b100));
            chk("hold_dat", 64'(rsp_dat_o), 64'(v.exp_dat));
            chk("hold_err", 64'(rsp_err_o), 64'(v.exp_err));
        end
        cmd_valid_i = 1'b0;
        WBs_ACK     = 1'b0;
        rsp_ready_i = 1'b1;
        if (rsp_valid_o) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'(sb.size()));
            end else begin
                got = sb.pop_front();
                chk("rsp_dat", 64'(rsp_dat_o), 64'(got.dat));
                chk("rsp_err", 64'(rsp_err_o), 64'(got.err));
            end
        end
        @(negedge WB_CLK);
        rsp_ready_i = 1'b0;
        chk_idle("post_rsp");
        // stray ACK while idle
        WBs_ACK    = 1'b1;
        WBs_RD_DAT = $urandom;
        @(negedge WB_CLK);
        WBs_ACK = 1'b0;
        chk_idle("idle_ack");
        chk("idle_rsp", 64'({rsp_dat_o, rsp_err_o}), 64'({v.exp_dat, v.exp_err}));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        repeat (2) @(negedge WB_CLK);
        chk_idle("reset");
        chk("reset_rsp", 64'({rsp_dat_o, rsp_err_o}), 64'd0);
        WB_RST = 1'b0;
        @(negedge WB_CLK);
        chk_idle("after_reset");

        //          we    adr        sel   dat           waits rd_dat        hold err  exp_dat       cyc
        vecs[0] = mk(1'b1, 17'h01000, 4'h3, 32'hA5A5_1234, 2,  32'h1111_1111, 0,  1'b0, 32'h0,         3);
        vecs[1] = mk(1'b0, 17'h01004, 4'h0, 32'h0000_0000, 0,  32'hCAFE_0001, 0,  1'b0, 32'hCAFE_0001, 1);
        vecs[2] = mk(1'b0, 17'h00010, 4'h0, 32'h0000_0010, 9,  32'h2222_2222, 2,  1'b1, 32'h0,         TO);
        vecs[3] = mk(1'b0, 17'h1FFFC, 4'h0, 32'h0000_0000, 3,  32'h1234_5678, 0,  1'b0, 32'h1234_5678, TO);
        vecs[4] = mk(1'b1, 17'h00020, 4'hC, 32'hDEAD_BEEF, 1,  32'h3333_3333, 10, 1'b0, 32'h0,         2);
        vecs[5] = mk(1'b0, 17'h00000, 4'h5, 32'h0BAD_F00D, 0,  32'hFFFF_FFFF, 1,  1'b0, 32'hFFFF_FFFF, 1);
        vecs[6] = mk(1'b1, 17'h10000, 4'hF, 32'h7777_8888, 9,  32'h4444_4444, 0,  1'b1, 32'h0,         TO);

        for (int k = 0; k < 7; k++) begin
            run_txn(vecs[k]);
        end

        // reset in the middle of a read with ACK arriving on the reset edge
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = 17'h00100;
        cmd_sel_i   = 4'h0;
        cmd_dat_i   = 32'h0;
        @(negedge WB_CLK);
        cmd_valid_i = 1'b0;
        chk("rst_seq_bus", 64'({WBs_CYC, WBs_RD}), 64'(2'b11));
        WBs_ACK    = 1'b1;
        WBs_RD_DAT = 32'h5555_AAAA;
        WB_RST     = 1'b1;
        @(negedge WB_CLK);
        WB_RST  = 1'b0;
        WBs_ACK = 1'b0;
        chk_idle("rst_mid");
        chk("rst_mid_rsp", 64'({rsp_dat_o, rsp_err_o}), 64'd0);
        g = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge WB_CLK);
            if (rsp_valid_o) g++;
        end
        chk("rst_no_rsp", 64'(g), 64'd0);

        run_txn(mk(1'b0, 17'h00104, 4'h0, 32'h0, 1, 32'h9ABC_DEF0, 0, 1'b0, 32'h9ABC_DEF0, 2));

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
